mem_seq: RTL and testbench
==========================

// Module: mem_seq
// PURPOSE
//  Memory access sequencer between the cpu core's external bus pins and the backing memory (SRAM/SDRAM port).
//  Converts cpu read/write/instr-fetch strobes into a single-outstanding req/ack transaction.
//  Builds 32-bit instructions from two 16-bit backend reads and reports busy/ready to the core's decoder and fetch logic.
//  Enforces a per-transaction timeout with a sticky error flag.
// PARAMETERS
//  TIMEOUT   256  backend cycles to wait for mem_ack before aborting a transaction (>=2)
//  ERR_DATA  16'hFFFF  data word returned on timeout (instr fetch returns {ERR_DATA,ERR_DATA})
// PORTS
//  clk               in   1   system clock; all state on rising edge
//  rst               in   1   synchronous reset, active-high
//  cpu_addr          in   16  data or instruction address from core
//  cpu_wdata         in   16  write data from core
//  cpu_read          in   1   read request, level; held by core until served
//  cpu_write         in   1   write request, level
//  cpu_instr_access  in   1   1 = access targets instruction space
//  cpu_read_done     in   1   core consumed read data; releases DONE
//  cpu_rdata         out  16  read data word; holds last value
//  cpu_instr         out  32  assembled instruction; holds last value
//  cpu_busy          out  1   transaction in progress
//  cpu_ready         out  1   read data valid / write complete
//  mem_addr          out  18  {space, word_addr[15:0], half}
//  mem_wdata         out  16  backend write data
//  mem_req           out  1   backend request, held until ack
//  mem_we            out  1   1 = write, valid while mem_req
//  mem_ack           in   1   backend completion; sampled only while mem_req=1
//  mem_rdata         in   16  backend read data, valid with mem_ack
//  err_timeout       out  1   sticky: a transaction timed out
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0 (cpu_rdata, cpu_instr, mem_addr, mem_wdata, err_timeout, counters cleared).
//  Reset mid-transaction: abort on the same edge; mem_req low next cycle; no ready pulse; late ack ignored.
//  States: IDLE, RD, WR, IF_LO, IF_HI, DONE, WDONE.
//  IDLE: busy=0, ready=0. On edge with cpu_write=1 -> WR (write wins if read also high).
//   Else cpu_read=1 & cpu_instr_access=1 -> IF_LO; cpu_read=1 & cpu_instr_access=0 -> RD.
//   Accepted addr/wdata/space are latched; core inputs are ignored until IDLE is re-entered.
//  RD/WR/IF_LO/IF_HI: busy=1, mem_req=1; mem_addr/mem_we/mem_wdata stable for the whole request.
//   Data accesses: half=0. IF_LO: half=0. IF_HI: half=1. Space bit = latched cpu_instr_access.
//   RD + ack: cpu_rdata<=mem_rdata -> DONE.  WR + ack -> WDONE.
//   IF_LO + ack: cpu_instr[15:0]<=mem_rdata -> IF_HI.  IF_HI + ack: cpu_instr[31:16]<=mem_rdata -> DONE.
//   mem_req drops for exactly one cycle between IF_LO and IF_HI; it is a new request.
//  Timeout: per-request counter, reset on entering each request state.
//   If TIMEOUT cycles elapse with no ack: load ERR_DATA into the target (both halves for a fetch), set err_timeout, go to DONE (WDONE for writes).
//   An ack arriving in the same cycle as expiry wins.
//  DONE: busy=0, ready=1; held until cpu_read_done=1, then IDLE the next cycle.
//  WDONE: ready=1 for exactly one cycle, then IDLE.
//  Each transaction spends at least one cycle in IDLE before the next one starts; no back-to-back acceptance.
//  Latency with zero-wait backend (ack in the first req cycle): accept edge k; req cycle k+1; ready from cycle k+2 (read/write).
//   Fetch: ready from cycle k+4.
//  err_timeout is cleared only by rst.
// TESTING
//  1 Read, ack after 3 cycles, mem_rdata=16'hBEEF: mem_addr=18'h0_2468 for cpu_addr=16'h1234; cpu_rdata=BEEF; ready held until read_done.
//  2 Instr fetch of cpu_addr=16'h0010, ack data 16'h1111 then 16'h2222: mem_addr 18'h20020 then 18'h20021; cpu_instr=32'h2222_1111.
//  3 Write cpu_addr=16'h00FF, wdata=16'hA5A5 with read also high: mem_we=1, mem_addr=18'h001FE, one-cycle ready, no read issued.
//  4 No ack, TIMEOUT=8: mem_req drops after 8 cycles; cpu_rdata=FFFF; err_timeout=1 and remains 1 after a later good read.
//  5 rst asserted during IF_HI: next cycle mem_req=0, busy=0, cpu_instr=0; a later ack causes no state change.
//  6 Spurious mem_ack while IDLE: ignored, outputs unchanged; zero-wait read meets k+2 ready latency.

Source files
------------

// File: rtl/mem_seq.sv
`default_nettype none
// ============================================================================
// Module   : mem_seq
// Purpose  : Memory access sequencer between the core's bus strobes and a
//            single-outstanding req/ack backend. Builds 32-bit instructions
//            from two 16-bit reads and aborts stalled requests on a timeout.
// Revision : 1.0  initial release
// ============================================================================
module mem_seq #(
  parameter int          TIMEOUT  = 256,
  parameter logic [15:0] ERR_DATA = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  input  logic        cpu_read,
  input  logic        cpu_write,
  input  logic        cpu_instr_access,
  input  logic        cpu_read_done,
  output logic [15:0] cpu_rdata,
  output logic [31:0] cpu_instr,
  output logic        cpu_busy,
  output logic        cpu_ready,
  output logic [17:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_req,
  output logic        mem_we,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic        err_timeout
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD    = 3'd1,
    WR    = 3'd2,
    IF_LO = 3'd3,
    IF_HI = 3'd4,
    DONE  = 3'd5,
    WDONE = 3'd6
  } state_t;

  state_t             state;
  state_t             state_nx;
  logic [15:0]        addr_q;
  logic [15:0]        wdata_q;
  logic               space_q;
  logic               hi_gap;     // first IF_HI cycle: request deasserted
  logic [CNT_W-1:0]   tmo_cnt;
  logic               accept;
  logic               ack_ok;
  logic               tmo_hit;

  // Backend request signalling; the IF_HI gap cycle separates the two fetch halves.
  assign mem_req   = (state == RD) || (state == WR) || (state == IF_LO) ||
                     ((state == IF_HI) && !hi_gap);
  assign mem_we    = (state == WR);
  assign mem_addr  = {space_q, addr_q, (state == IF_HI)};
  assign mem_wdata = wdata_q;

  // Ack is only meaningful while a request is up; an ack on the expiry cycle wins.
  assign ack_ok  = mem_req && mem_ack;
  assign tmo_hit = mem_req && !mem_ack && (tmo_cnt == CNT_W'(TIMEOUT - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nx  = state;
    cpu_busy  = 1'b0;
    cpu_ready = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_write) begin
          state_nx = WR;
          accept   = 1'b1;
        end else if (cpu_read) begin
          state_nx = cpu_instr_access ? IF_LO : RD;
          accept   = 1'b1;
        end
      end
      RD: begin
        cpu_busy = 1'b1;
        if (ack_ok || tmo_hit) state_nx = DONE;
      end
      WR: begin
        cpu_busy = 1'b1;
        if (ack_ok || tmo_hit) state_nx = WDONE;
      end
      IF_LO: begin
        cpu_busy = 1'b1;
        if (ack_ok)       state_nx = IF_HI;
        else if (tmo_hit) state_nx = DONE;
      end
      IF_HI: begin
        cpu_busy = 1'b1;
        if (ack_ok || tmo_hit) state_nx = DONE;
      end
      DONE: begin
        cpu_ready = 1'b1;
        if (cpu_read_done) state_nx = IDLE;
      end
      WDONE: begin
        cpu_ready = 1'b1;
        state_nx  = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Request latching, timeout counting and read-data capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q      <= 16'h0000;
      wdata_q     <= 16'h0000;
      space_q     <= 1'b0;
      hi_gap      <= 1'b0;
      tmo_cnt     <= '0;
      cpu_rdata   <= 16'h0000;
      cpu_instr   <= 32'h0000_0000;
      err_timeout <= 1'b0;
    end else begin
      if (accept) begin
        addr_q  <= cpu_addr;
        wdata_q <= cpu_wdata;
        space_q <= cpu_instr_access;
      end
      hi_gap <= (state == IF_LO) && ack_ok;
      // Every request state is entered from a non-request cycle, so the
      // counter always starts from zero for a new request.
      if (mem_req && !ack_ok && !tmo_hit) tmo_cnt <= tmo_cnt + 1'b1;
      else                                tmo_cnt <= '0;
      if (tmo_hit) err_timeout <= 1'b1;
      case (state)
        RD: begin
          if (ack_ok)       cpu_rdata <= mem_rdata;
          else if (tmo_hit) cpu_rdata <= ERR_DATA;
        end
        IF_LO: begin
          if (ack_ok)       cpu_instr[15:0] <= mem_rdata;
          else if (tmo_hit) cpu_instr       <= {ERR_DATA, ERR_DATA};
        end
        IF_HI: begin
          if (ack_ok)       cpu_instr[31:16] <= mem_rdata;
          else if (tmo_hit) cpu_instr        <= {ERR_DATA, ERR_DATA};
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_seq
// Purpose  : Directed self-checking bench for mem_seq with a scoreboard queue
//            of expected read/fetch results.
// Revision : 1.0  initial release
// ============================================================================
module tb_mem_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic        cpu_read;
  logic        cpu_write;
  logic        cpu_instr_access;
  logic        cpu_read_done;
  logic [15:0] cpu_rdata;
  logic [31:0] cpu_instr;
  logic        cpu_busy;
  logic        cpu_ready;
  logic [17:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_req;
  logic        mem_we;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        err_timeout;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  mem_seq #(.TIMEOUT(8), .ERR_DATA(16'hFFFF)) dut (
    .clk(clk), .rst(rst),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_instr_access(cpu_instr_access), .cpu_read_done(cpu_read_done),
    .cpu_rdata(cpu_rdata), .cpu_instr(cpu_instr),
    .cpu_busy(cpu_busy), .cpu_ready(cpu_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Pop the oldest expected result and compare it with what the DUT now shows.
  task automatic pop_chk(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s observed=%h expected=<empty scoreboard>", tag, obs);
    end else begin
      e = exp_q.pop_front();
      chk(tag, obs, e);
    end
  endtask

  // Release a held DONE state.
  task automatic finish_read();
    cpu_read_done = 1'b1;
    step();
    cpu_read_done = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cpu_addr = 16'h0; cpu_wdata = 16'h0; cpu_read = 1'b0;
    cpu_write = 1'b0; cpu_instr_access = 1'b0; cpu_read_done = 1'b0;
    mem_ack = 1'b0; mem_rdata = 16'h0;
    step();
    step();
    rst = 1'b0;
    chk("rst_busy",  {31'd0, cpu_busy},  32'd0);
    chk("rst_ready", {31'd0, cpu_ready}, 32'd0);
    chk("rst_req",   {31'd0, mem_req},   32'd0);
    chk("rst_addr",  {14'd0, mem_addr},  32'd0);
    chk("rst_rdata", {16'd0, cpu_rdata}, 32'd0);
    chk("rst_instr", cpu_instr,          32'd0);
    chk("rst_err",   {31'd0, err_timeout}, 32'd0);

    // Spurious ack while idle.
    mem_ack = 1'b1; mem_rdata = 16'h1234;
    step();
    mem_ack = 1'b0;
    chk("spur_busy",  {31'd0, cpu_busy},  32'd0);
    chk("spur_req",   {31'd0, mem_req},   32'd0);
    chk("spur_rdata", {16'd0, cpu_rdata}, 32'd0);

    // Read with ack in the third request cycle.
    cpu_read = 1'b1; cpu_addr = 16'h1234; cpu_instr_access = 1'b0;
    exp_q.push_back(32'h0000_BEEF);
    step();
    chk("rd_req",  {31'd0, mem_req}, 32'd1);
    chk("rd_addr", {14'd0, mem_addr}, 32'h0002_468);
    chk("rd_we",   {31'd0, mem_we},  32'd0);
    chk("rd_busy", {31'd0, cpu_busy}, 32'd1);
    step();
    step();
    chk("rd_req3", {31'd0, mem_req}, 32'd1);
    mem_ack = 1'b1; mem_rdata = 16'hBEEF;
    step();
    mem_ack = 1'b0; cpu_read = 1'b0;
    chk("rd_ready", {31'd0, cpu_ready}, 32'd1);
    chk("rd_done_busy", {31'd0, cpu_busy}, 32'd0);
    pop_chk("rd_data", {16'd0, cpu_rdata});
    step();
    chk("rd_ready_hold", {31'd0, cpu_ready}, 32'd1);
    finish_read();
    chk("rd_idle_ready", {31'd0, cpu_ready}, 32'd0);

    // Instruction fetch, zero-wait backend.
    cpu_read = 1'b1; cpu_addr = 16'h0010; cpu_instr_access = 1'b1;
    exp_q.push_back(32'h2222_1111);
    step();
    chk("if_lo_req",  {31'd0, mem_req}, 32'd1);
    chk("if_lo_addr", {14'd0, mem_addr}, 32'h0002_0020);
    mem_ack = 1'b1; mem_rdata = 16'h1111;
    step();
    mem_ack = 1'b0;
    chk("if_gap_req",  {31'd0, mem_req},  32'd0);
    chk("if_gap_busy", {31'd0, cpu_busy}, 32'd1);
    step();
    cpu_read = 1'b0;
    chk("if_hi_req",   {31'd0, mem_req},   32'd1);
    chk("if_hi_addr",  {14'd0, mem_addr},  32'h0002_0021);
    chk("if_hi_ready", {31'd0, cpu_ready}, 32'd0);
    mem_ack = 1'b1; mem_rdata = 16'h2222;
    step();
    mem_ack = 1'b0;
    chk("if_ready", {31'd0, cpu_ready}, 32'd1);
    pop_chk("if_instr", cpu_instr);
    finish_read();

    // Write with read also asserted: write wins.
    cpu_write = 1'b1; cpu_read = 1'b1; cpu_instr_access = 1'b0;
    cpu_addr = 16'h00FF; cpu_wdata = 16'hA5A5;
    step();
    chk("wr_we",    {31'd0, mem_we},   32'd1);
    chk("wr_addr",  {14'd0, mem_addr}, 32'h0000_01FE);
    chk("wr_wdata", {16'd0, mem_wdata}, 32'h0000_A5A5);
    cpu_write = 1'b0; cpu_read = 1'b0;
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    chk("wr_ready", {31'd0, cpu_ready}, 32'd1);
    chk("wr_req_off", {31'd0, mem_req}, 32'd0);
    step();
    chk("wr_ready_1cyc", {31'd0, cpu_ready}, 32'd0);
    chk("wr_no_read", {31'd0, mem_req}, 32'd0);

    // Read with no ack: timeout after 8 request cycles.
    cpu_read = 1'b1; cpu_addr = 16'h0005;
    exp_q.push_back(32'h0000_FFFF);
    step();
    cpu_read = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("tmo_req%0d", i), {31'd0, mem_req}, 32'd1);
      step();
    end
    chk("tmo_req_off", {31'd0, mem_req}, 32'd0);
    chk("tmo_ready",   {31'd0, cpu_ready}, 32'd1);
    chk("tmo_err",     {31'd0, err_timeout}, 32'd1);
    pop_chk("tmo_data", {16'd0, cpu_rdata});
    finish_read();

    // Good zero-wait read afterwards: ready at k+2, error stays sticky.
    cpu_read = 1'b1; cpu_addr = 16'h0006;
    exp_q.push_back(32'h0000_0042);
    step();
    cpu_read = 1'b0;
    chk("zw_ready_k1", {31'd0, cpu_ready}, 32'd0);
    mem_ack = 1'b1; mem_rdata = 16'h0042;
    step();
    mem_ack = 1'b0;
    chk("zw_ready_k2", {31'd0, cpu_ready}, 32'd1);
    pop_chk("zw_data", {16'd0, cpu_rdata});
    chk("err_sticky", {31'd0, err_timeout}, 32'd1);
    finish_read();

    // Reset during the IF_HI request.
    cpu_read = 1'b1; cpu_addr = 16'h0030; cpu_instr_access = 1'b1;
    step();
    mem_ack = 1'b1; mem_rdata = 16'h3333;
    step();
    mem_ack = 1'b0; cpu_read = 1'b0;
    step();
    chk("rst_ifhi_req_pre", {31'd0, mem_req}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_ifhi_req",   {31'd0, mem_req},  32'd0);
    chk("rst_ifhi_busy",  {31'd0, cpu_busy}, 32'd0);
    chk("rst_ifhi_instr", cpu_instr,         32'd0);
    mem_ack = 1'b1; mem_rdata = 16'h4444;
    step();
    mem_ack = 1'b0;
    chk("late_ack_busy",  {31'd0, cpu_busy},  32'd0);
    chk("late_ack_ready", {31'd0, cpu_ready}, 32'd0);
    chk("late_ack_instr", cpu_instr,          32'd0);
    chk("sb_empty", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
